decode_queue: RTL

- Parametrised decode-stage successor for the RV64IM pipeline.
- Buffers fetched (pc, instr) pairs in a DEPTH-entry FIFO and decodes the head into a registered, self-contained bundle: class, immediate, register indices, write-enable and illegal flag.
- Uses valid/ready handshakes on both sides and supports a synchronous flush.
- Sits between fetch and the issue/execute stage.

---
 rtl/decode_queue.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : FIFO of fetched (pc, instr) pairs feeding a registered RV64IM
//               decode bundle, valid/ready on both sides, synchronous flush.
//               Optional M-extension decode is enabled by DECODE_MEXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_instr,
    output logic [3:0]             out_cls,
    output logic                   out_word,
    output logic [XLEN-1:0]        out_imm,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic                   out_regwrite,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    localparam logic [3:0] c_cls_alu    = 4'd0;
    localparam logic [3:0] c_cls_alui   = 4'd1;
    localparam logic [3:0] c_cls_lui    = 4'd2;
    localparam logic [3:0] c_cls_auipc  = 4'd3;
    localparam logic [3:0] c_cls_branch = 4'd4;
    localparam logic [3:0] c_cls_jal    = 4'd5;
    localparam logic [3:0] c_cls_jalr   = 4'd6;
    localparam logic [3:0] c_cls_load   = 4'd7;
    localparam logic [3:0] c_cls_store  = 4'd8;
    localparam logic [3:0] c_cls_muldiv = 4'd9;
    localparam logic [3:0] c_cls_ill    = 4'd15;

    localparam logic [6:0] c_op_lui     = 7'b0110111;
    localparam logic [6:0] c_op_auipc   = 7'b0010111;
    localparam logic [6:0] c_op_jal     = 7'b1101111;
    localparam logic [6:0] c_op_jalr    = 7'b1100111;
    localparam logic [6:0] c_op_branch  = 7'b1100011;
    localparam logic [6:0] c_op_load    = 7'b0000011;
    localparam logic [6:0] c_op_store   = 7'b0100011;
    localparam logic [6:0] c_op_imm     = 7'b0010011;
    localparam logic [6:0] c_op_imm_32  = 7'b0011011;
    localparam logic [6:0] c_op         = 7'b0110011;
    localparam logic [6:0] c_op_32      = 7'b0111011;

    logic [XLEN+31:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [3:0]       out_cls_q, out_cls_d;
    logic             out_word_q, out_word_d, out_regwrite_q, out_regwrite_d;

    logic             fifo_empty, reg_free, accept, pop, bypass, push, load;
    logic [XLEN-1:0]  src_pc;
    logic [31:0]      src_instr;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh6, imm_sh5;
    logic [3:0]       dec_cls;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_word, dec_regwrite;

    assign fifo_empty = (count_q == '0);
    assign reg_free   = !out_valid_q || out_ready;
    assign in_ready   = (count_q < c_depth) && !flush;
    assign accept     = in_valid && in_ready;
    assign pop        = reg_free && !fifo_empty && !flush;
    assign bypass     = reg_free && fifo_empty && accept;
    assign push       = accept && !bypass;
    assign load       = pop || bypass;

    // Decode source: FIFO head when occupied, otherwise the incoming instruction.
    assign {src_pc, src_instr} = fifo_empty ? {in_pc, in_instr} : mem_q[rd_ptr_q];

    assign opc = src_instr[6:0];
    assign f3  = src_instr[14:12];
    assign f7  = src_instr[31:25];

    assign imm_i   = {{(XLEN-12){src_instr[31]}}, src_instr[31:20]};
    assign imm_s   = {{(XLEN-12){src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
    assign imm_b   = {{(XLEN-13){src_instr[31]}}, src_instr[31], src_instr[7],
                      src_instr[30:25], src_instr[11:8], 1'b0};
    assign imm_u   = {{(XLEN-32){src_instr[31]}}, src_instr[31:12], 12'b0};
    assign imm_j   = {{(XLEN-21){src_instr[31]}}, src_instr[31], src_instr[19:12],
                      src_instr[20], src_instr[30:21], 1'b0};
    assign imm_sh6 = {{(XLEN-6){1'b0}}, src_instr[25:20]};
    assign imm_sh5 = {{(XLEN-5){1'b0}}, src_instr[24:20]};

    always_comb begin
        dec_cls  = c_cls_ill;
        dec_imm  = '0;
        dec_word = 1'b0;
        case (opc)
            c_op_lui:    begin dec_cls = c_cls_lui;   dec_imm = imm_u; end
            c_op_auipc:  begin dec_cls = c_cls_auipc; dec_imm = imm_u; end
            c_op_jal:    begin dec_cls = c_cls_jal;   dec_imm = imm_j; end
            c_op_jalr:   if (f3 == 3'b000) begin dec_cls = c_cls_jalr; dec_imm = imm_i; end
            c_op_branch: if (f3 != 3'b010 && f3 != 3'b011) begin
                             dec_cls = c_cls_branch; dec_imm = imm_b;
                         end
            c_op_load:   if (f3 != 3'b111) begin dec_cls = c_cls_load; dec_imm = imm_i; end
            c_op_store:  if (!f3[2]) begin dec_cls = c_cls_store; dec_imm = imm_s; end
            c_op_imm: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    if (src_instr[31:26] == 6'b000000 || src_instr[31:26] == 6'b010000) begin
                        dec_cls = c_cls_alui; dec_imm = imm_sh6;
                    end
                end else begin
                    dec_cls = c_cls_alui; dec_imm = imm_i;
                end
            end
            c_op_imm_32: begin
                if (f3 == 3'b000) begin
                    dec_cls = c_cls_alui; dec_imm = imm_i; dec_word = 1'b1;
                end else if ((f3 == 3'b001 || f3 == 3'b101) && !src_instr[25]) begin
                    dec_cls = c_cls_alui; dec_imm = imm_sh5; dec_word = 1'b1;
                end
            end
            c_op: begin
                case (f7)
                    7'b0000000: dec_cls = c_cls_alu;
                    7'b0100000: if (f3 == 3'b000 || f3 == 3'b101) dec_cls = c_cls_alu;
`ifdef DECODE_MEXT_EN
                    7'b0000001: dec_cls = c_cls_muldiv;
`endif
                    default:    dec_cls = c_cls_ill;
                endcase
            end
            c_op_32: begin
                case (f7)
                    7'b0000000: if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) begin
                                    dec_cls = c_cls_alu; dec_word = 1'b1;
                                end
                    7'b0100000: if (f3 == 3'b000 || f3 == 3'b101) begin
                                    dec_cls = c_cls_alu; dec_word = 1'b1;
                                end
`ifdef DECODE_MEXT_EN
                    // MULW and the word divides; funct3 001/011 have no W form.
                    7'b0000001: if (f3 == 3'b000 || f3[2]) begin
                                    dec_cls = c_cls_muldiv; dec_word = 1'b1;
                                end
`endif
                    default:    dec_cls = c_cls_ill;
                endcase
            end
            default: dec_cls = c_cls_ill;
        endcase

        case (dec_cls)
            c_cls_alu, c_cls_alui, c_cls_lui, c_cls_auipc,
            c_cls_jal, c_cls_jalr, c_cls_load, c_cls_muldiv: dec_regwrite = 1'b1;
            default:                                         dec_regwrite = 1'b0;
        endcase
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_instr_d    = out_instr_q;
        out_cls_d      = out_cls_q;
        out_imm_d      = out_imm_q;
        out_word_d     = out_word_q;
        out_regwrite_d = out_regwrite_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (load) begin
                out_valid_d    = 1'b1;
                out_pc_d       = src_pc;
                out_instr_d    = src_instr;
                out_cls_d      = dec_cls;
                out_imm_d      = dec_imm;
                out_word_d     = dec_word;
                out_regwrite_d = dec_regwrite;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_instr_q    <= '0;
            out_cls_q      <= '0;
            out_imm_q      <= '0;
            out_word_q     <= 1'b0;
            out_regwrite_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_instr_q    <= out_instr_d;
            out_cls_q      <= out_cls_d;
            out_imm_q      <= out_imm_d;
            out_word_q     <= out_word_d;
            out_regwrite_q <= out_regwrite_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_pc, in_instr};
    end

    assign count        = count_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_instr    = out_instr_q;
    assign out_cls      = out_cls_q;
    assign out_word     = out_word_q;
    assign out_imm      = out_imm_q;
    assign out_rd       = out_instr_q[11:7];
    assign out_rs1      = out_instr_q[19:15];
    assign out_rs2      = out_instr_q[24:20];
    assign out_regwrite = out_regwrite_q;
    assign out_illegal  = (out_cls_q == c_cls_ill);

endmodule
`default_nettype wire
